// File: rtl/ppu_frame_timing_if.sv
// Bundle between the PPU register file / render pipeline (master) and the frame timing
// sequencer (slave).
//   i_ce            pixel-clock enable
//   i_rendering_en  PPUMASK background|sprite enable
//   i_nmi_enable    PPUCTRL[7]
//   i_status_read   one-clock strobe for a CPU read of PPUSTATUS
//   o_dot           current dot, 0..340
//   o_scanline      current scanline, 0..261
//   o_vblank        VBlank flag (PPUSTATUS[7])
//   o_nmi_n         active-low NMI to the CPU
//   o_frame_odd     frame parity
//   o_visible       inside the visible picture area
//   o_frame_start   one-clock pulse when the raster wraps to (0,0)
interface ppu_frame_timing_if;
  logic       i_ce;
  logic       i_rendering_en;
  logic       i_nmi_enable;
  logic       i_status_read;
  logic [8:0] o_dot;
  logic [8:0] o_scanline;
  logic       o_vblank;
  logic       o_nmi_n;
  logic       o_frame_odd;
  logic       o_visible;
  logic       o_frame_start;

  modport master (
    output i_ce, i_rendering_en, i_nmi_enable, i_status_read,
    input  o_dot, o_scanline, o_vblank, o_nmi_n, o_frame_odd, o_visible, o_frame_start
  );

  modport slave (
    input  i_ce, i_rendering_en, i_nmi_enable, i_status_read,
    output o_dot, o_scanline, o_vblank, o_nmi_n, o_frame_odd, o_visible, o_frame_start
  );
endinterface

// File: rtl/ppu_frame_timing.sv
// 2C02 dot/scanline sequencer. Walks the raster one dot per enabled clock, owns the VBlank
// flag, drives ~NMI and emits the frame-start / visible-area strobes.
//   i_clk      system clock, all state on the rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        ppu_frame_timing_if slave modport (see interface for signal list)
module ppu_frame_timing #(
  parameter int unsigned DOTS_PER_LINE   = 341,
  parameter int unsigned LINES_PER_FRAME = 262,
  parameter int unsigned VBLANK_LINE     = 241,
  parameter int unsigned PRERENDER_LINE  = 261
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  ppu_frame_timing_if.slave  bus
);

  localparam logic [8:0] LastDot       = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SkipDot       = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LastLine      = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VblankLine    = 9'(VBLANK_LINE);
  localparam logic [8:0] PrerenderLine = 9'(PRERENDER_LINE);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       vblank_q, vblank_d;
  logic       fstart_q, fstart_d;
  logic       last_dot;
  logic       wrap;

  always_comb begin
    last_dot = (dot_q == LastDot);
    // Odd frames with rendering on drop the final dot of the pre-render line.
    wrap     = (line_q == LastLine) &&
               (last_dot || ((dot_q == SkipDot) && odd_q && bus.i_rendering_en));

    dot_d    = dot_q;
    line_d   = line_q;
    odd_d    = odd_q;
    vblank_d = vblank_q;
    fstart_d = 1'b0;

    if (bus.i_ce) begin
      if (wrap) begin
        dot_d    = '0;
        line_d   = '0;
        odd_d    = ~odd_q;
        fstart_d = 1'b1;
      end else if (last_dot) begin
        dot_d  = '0;
        line_d = line_q + 9'd1;
      end else begin
        dot_d = dot_q + 9'd1;
      end

      // Dot 0 of these lines always steps to dot 1, so these are the "becomes (L,1)" edges.
      if ((dot_q == '0) && (line_q == VblankLine)) begin
        vblank_d = 1'b1;
      end else if ((dot_q == '0) && (line_q == PrerenderLine)) begin
        vblank_d = 1'b0;
      end
    end

    // A status read on the set edge suppresses the flag for the whole frame.
    if (bus.i_status_read) begin
      vblank_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dot_q    <= '0;
      line_q   <= '0;
      odd_q    <= 1'b0;
      vblank_q <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      dot_q    <= dot_d;
      line_q   <= line_d;
      odd_q    <= odd_d;
      vblank_q <= vblank_d;
      fstart_q <= fstart_d;
    end
  end

  assign bus.o_dot         = dot_q;
  assign bus.o_scanline    = line_q;
  assign bus.o_vblank      = vblank_q;
  assign bus.o_nmi_n       = ~(vblank_q & bus.i_nmi_enable);
  assign bus.o_frame_odd   = odd_q;
  assign bus.o_frame_start = fstart_q;
  assign bus.o_visible     = (line_q < 9'd240) && (dot_q != '0) && (dot_q <= 9'd256);

endmodule

// File: tb/tb_ppu_frame_timing.sv
module tb_ppu_frame_timing;

  // Reduced raster for multi-frame and randomized checks.
  localparam int SD   = 20;
  localparam int SL   = 12;
  localparam int SV   = 8;
  localparam int SP   = 11;
  localparam int SLEN = SD * SL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_big_n = 1'b1;
  logic rst_sm_n  = 1'b1;

  ppu_frame_timing_if bb ();
  ppu_frame_timing_if bs ();

  ppu_frame_timing u_big (
    .i_clk     (clk),
    .i_reset_n (rst_big_n),
    .bus       (bb)
  );

  ppu_frame_timing #(
    .DOTS_PER_LINE   (SD),
    .LINES_PER_FRAME (SL),
    .VBLANK_LINE     (SV),
    .PRERENDER_LINE  (SP)
  ) u_small (
    .i_clk     (clk),
    .i_reset_n (rst_sm_n),
    .bus       (bs)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- full-size raster
  typedef struct {
    int n;      // cumulative enabled clocks since reset release
    int dot;
    int line;
    bit vis;
    bit vb;
    bit fs;
    bit odd;
  } cp_t;

  task automatic big_cmp(input cp_t c);
    string t;
    t = $sformatf("big@%0d", c.n);
    chk({t, " dot"},   32'(bb.o_dot),         32'(c.dot));
    chk({t, " line"},  32'(bb.o_scanline),    32'(c.line));
    chk({t, " vis"},   32'(bb.o_visible),     32'(c.vis));
    chk({t, " vb"},    32'(bb.o_vblank),      32'(c.vb));
    chk({t, " nmi_n"}, 32'(bb.o_nmi_n),       32'(!c.vb));
    chk({t, " fs"},    32'(bb.o_frame_start), 32'(c.fs));
    chk({t, " odd"},   32'(bb.o_frame_odd),   32'(c.odd));
  endtask

  task automatic run_big();
    cp_t cps[16];
    int  n;
    n = 0;
    cps[0]  = '{0,     0,   0,   1'b0, 1'b0, 1'b0, 1'b0};
    cps[1]  = '{1,     1,   0,   1'b1, 1'b0, 1'b0, 1'b0};
    cps[2]  = '{256,   256, 0,   1'b1, 1'b0, 1'b0, 1'b0};
    cps[3]  = '{257,   257, 0,   1'b0, 1'b0, 1'b0, 1'b0};
    cps[4]  = '{340,   340, 0,   1'b0, 1'b0, 1'b0, 1'b0};
    cps[5]  = '{341,   0,   1,   1'b0, 1'b0, 1'b0, 1'b0};
    cps[6]  = '{81500, 1,   239, 1'b1, 1'b0, 1'b0, 1'b0};
    cps[7]  = '{81755, 256, 239, 1'b1, 1'b0, 1'b0, 1'b0};
    cps[8]  = '{81841, 1,   240, 1'b0, 1'b0, 1'b0, 1'b0};
    cps[9]  = '{82181, 0,   241, 1'b0, 1'b0, 1'b0, 1'b0};
    cps[10] = '{82182, 1,   241, 1'b0, 1'b1, 1'b0, 1'b0};
    cps[11] = '{89001, 0,   261, 1'b0, 1'b0, 1'b0, 1'b0};
    cps[12] = '{89002, 1,   261, 1'b0, 1'b0, 1'b0, 1'b0};
    cps[13] = '{89341, 340, 261, 1'b0, 1'b0, 1'b0, 1'b0};
    cps[14] = '{89342, 0,   0,   1'b0, 1'b0, 1'b1, 1'b1};
    cps[15] = '{89343, 1,   0,   1'b1, 1'b0, 1'b0, 1'b1};

    bb.i_ce = 1'b0; bb.i_rendering_en = 1'b1; bb.i_nmi_enable = 1'b1; bb.i_status_read = 1'b0;
    #2 rst_big_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("big reset dot",   32'(bb.o_dot),         0);
    chk("big reset line",  32'(bb.o_scanline),    0);
    chk("big reset vb",    32'(bb.o_vblank),      0);
    chk("big reset nmi_n", 32'(bb.o_nmi_n),       1);
    chk("big reset odd",   32'(bb.o_frame_odd),   0);
    chk("big reset fs",    32'(bb.o_frame_start), 0);
    rst_big_n = 1'b1;
    bb.i_ce   = 1'b1;

    for (int i = 0; i < 16; i++) begin
      while (n < cps[i].n) begin
        @(posedge clk);
        n++;
      end
      #1;
      big_cmp(cps[i]);
      if (cps[i].vb) begin
        // NMI enable toggling and status read while VBlank is up; raster held.
        bb.i_ce = 1'b0;
        bb.i_nmi_enable = 1'b0; #1;
        chk("t5 nmi disable", 32'(bb.o_nmi_n), 1);
        bb.i_nmi_enable = 1'b1; #1;
        chk("t5 nmi enable", 32'(bb.o_nmi_n), 0);
        bb.i_status_read = 1'b1; #1;
        chk("t5 flag before read edge", 32'(bb.o_vblank), 1);
        @(posedge clk);
        #1;
        bb.i_status_read = 1'b0;
        chk("t5 vb after read", 32'(bb.o_vblank), 0);
        chk("t5 nmi after read", 32'(bb.o_nmi_n), 1);
        chk("t5 dot hold ce0", 32'(bb.o_dot), 1);
        bb.i_nmi_enable = 1'b0; #1;
        bb.i_nmi_enable = 1'b1; #1;
        chk("t5 re-enable no nmi", 32'(bb.o_nmi_n), 1);
        bb.i_ce = 1'b1;
      end
    end

    // Asynchronous reset mid-frame on an odd frame.
    rst_big_n = 1'b0;
    #1;
    chk("big async rst dot",  32'(bb.o_dot),         0);
    chk("big async rst line", 32'(bb.o_scanline),    0);
    chk("big async rst odd",  32'(bb.o_frame_odd),   0);
    chk("big async rst vb",   32'(bb.o_vblank),      0);
    chk("big async rst nmi",  32'(bb.o_nmi_n),       1);
    chk("big async rst fs",   32'(bb.o_frame_start), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("big rst hold dot", 32'(bb.o_dot), 0);
    rst_big_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- reduced raster + model
  int m_pos;
  bit m_odd;
  bit m_vb;
  bit m_fs;
  bit sm_fs_seen;

  task automatic sm_cycle(input bit ce, input bit ren, input bit nen, input bit rd);
    int d;
    int l;
    @(negedge clk);
    bs.i_ce = ce; bs.i_rendering_en = ren; bs.i_nmi_enable = nen; bs.i_status_read = rd;
    #1;
    d = m_pos % SD;
    l = m_pos / SD;
    sm_fs_seen = bs.o_frame_start;
    chk("sm dot",   32'(bs.o_dot),         32'(d));
    chk("sm line",  32'(bs.o_scanline),    32'(l));
    chk("sm vis",   32'(bs.o_visible),     32'((l < 240) && (d >= 1) && (d <= 256)));
    chk("sm vb",    32'(bs.o_vblank),      32'(m_vb));
    chk("sm nmi_n", 32'(bs.o_nmi_n),       32'(!(m_vb && nen)));
    chk("sm odd",   32'(bs.o_frame_odd),   32'(m_odd));
    chk("sm fs",    32'(bs.o_frame_start), 32'(m_fs));
    // Model of the following clock edge.
    m_fs = 1'b0;
    if (ce) begin
      if ((m_pos == SLEN - 1) || ((m_pos == SLEN - 2) && m_odd && ren)) begin
        m_pos = 0;
        m_odd = !m_odd;
        m_fs  = 1'b1;
      end else begin
        m_pos++;
      end
      if (m_pos == SV * SD + 1) m_vb = 1'b1;
      else if (m_pos == SP * SD + 1) m_vb = 1'b0;
    end
    if (rd) m_vb = 1'b0;
  endtask

  task automatic sm_reset(input int hold);
    #2;
    rst_sm_n = 1'b0;
    #1;
    chk("sm rst dot",   32'(bs.o_dot),         0);
    chk("sm rst line",  32'(bs.o_scanline),    0);
    chk("sm rst vb",    32'(bs.o_vblank),      0);
    chk("sm rst nmi_n", 32'(bs.o_nmi_n),       1);
    chk("sm rst odd",   32'(bs.o_frame_odd),   0);
    chk("sm rst fs",    32'(bs.o_frame_start), 0);
    repeat (hold) begin
      @(negedge clk);
      bs.i_ce = 1'($urandom_range(0, 1));
      bs.i_status_read = 1'b0;
      #1;
      chk("sm rst hold dot",  32'(bs.o_dot),      0);
      chk("sm rst hold line", 32'(bs.o_scanline), 0);
    end
    @(negedge clk);
    bs.i_ce = 1'b0;
    bs.i_status_read = 1'b0;
    rst_sm_n = 1'b1;
    m_pos = 0; m_odd = 1'b0; m_vb = 1'b0; m_fs = 1'b0;
  endtask

  task automatic sm_frames(input bit ren, input int exp_even, input int exp_odd);
    int e;
    int p[$];
    e = 0;
    sm_reset(2);
    for (int i = 0; i < 700 && p.size() < 2; i++) begin
      sm_cycle(1'b1, ren, 1'b0, 1'b0);
      if (sm_fs_seen) p.push_back(e);
      e++;
    end
    if (p.size() < 2) begin
      chk($sformatf("frame pulses ren=%0d", ren), 32'(p.size()), 2);
    end else begin
      chk($sformatf("even frame len ren=%0d", ren), 32'(p[0]), 32'(exp_even));
      chk($sformatf("odd frame len ren=%0d", ren), 32'(p[1] - p[0]), 32'(exp_odd));
    end
  endtask

  task automatic run_small();
    bs.i_ce = 1'b0; bs.i_rendering_en = 1'b0; bs.i_nmi_enable = 1'b0; bs.i_status_read = 1'b0;

    sm_frames(1'b0, SLEN, SLEN);
    sm_frames(1'b1, SLEN, SLEN - 1);

    // Read one clock before the set edge: old flag seen, set still happens.
    sm_reset(1);
    for (int i = 0; i < SV * SD - 1; i++) sm_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    sm_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4a flag read", 32'(bs.o_vblank), 0);
    sm_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    sm_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4a set", 32'(bs.o_vblank), 1);
    chk("t4a nmi", 32'(bs.o_nmi_n), 0);

    // Read on the set edge: flag suppressed through the pre-render clear point.
    sm_reset(1);
    for (int i = 0; i < SV * SD; i++) sm_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    sm_cycle(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < (SP - SV) * SD; i++) sm_cycle(1'b1, 1'b1, 1'b1, 1'b0);
    sm_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t4b line", 32'(bs.o_scanline), 32'(SP));
    chk("t4b vb", 32'(bs.o_vblank), 0);
    chk("t4b nmi", 32'(bs.o_nmi_n), 1);

    // Randomized traffic with a mid-run asynchronous reset.
    sm_reset(2);
    for (int i = 0; i < 5000; i++) begin
      if (i == 2500) sm_reset(3);
      sm_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      run_big();
      run_small();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
